// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Transmit FIFO that queues bytes and paces them into the
//               UART core on tx_busy. Optional statistics enabled by
//               defining UART_TX_FIFO_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_BITS    = 8,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_BITS:0]    count,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_busy,
    output logic                  idle,
    output logic                  overflow,
    output logic [15:0]           drop_cnt
);

    localparam int c_DEPTH   = 1 << ADDR_BITS;
    localparam int c_TIMER_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    localparam logic [ADDR_BITS:0]   c_FULL_COUNT = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_HI = 2'd1,
        S_WAIT_LO = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [c_TIMER_W-1:0]    r_timer;
    logic [c_TIMER_W-1:0]    w_timer_next;
    logic                    w_launch;

    logic [DATA_WIDTH-1:0]   r_mem [c_DEPTH];
    logic [ADDR_BITS-1:0]    r_wr_ptr;
    logic [ADDR_BITS-1:0]    r_rd_ptr;
    logic [ADDR_BITS:0]      r_count;
    logic [ADDR_BITS:0]      w_count_next;
    logic                    r_full;
    logic                    r_empty;
    logic                    w_wr_ok;
    logic                    r_tx_valid;
    logic [DATA_WIDTH-1:0]   r_tx_data;

    // Full is the registered flag, so a pop in the same cycle never frees
    // a slot for a concurrent write.
    assign w_wr_ok = wr_en && !r_full && !clear;

    always_comb begin
        w_count_next = r_count;
        if (clear) begin
            w_count_next = '0;
        end else begin
            case ({w_wr_ok, w_launch})
                2'b10:   w_count_next = r_count + 1'b1;
                2'b01:   w_count_next = r_count - 1'b1;
                default: w_count_next = r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (clear) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_ok) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_launch) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_FULL_COUNT);
            r_empty <= (w_count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_launch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_empty && !tx_busy) begin
                    w_launch     = 1'b1;
                    w_timer_next = '0;
                    w_state_next = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                // Give up waiting for the core to acknowledge after the timeout.
                if (tx_busy) begin
                    w_state_next = S_WAIT_LO;
                end else if (r_timer == c_TIMER_LAST) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            S_WAIT_LO: begin
                if (!tx_busy) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_tx_valid <= w_launch;
            if (w_launch) begin
                r_tx_data <= r_mem[r_rd_ptr];
            end
        end
    end

`ifdef UART_TX_FIFO_STATS_EN
    logic        r_overflow;
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (wr_en && r_full) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;
`else
    assign overflow = 1'b0;
    assign drop_cnt = 16'h0000;
`endif

    assign full     = r_full;
    assign empty    = r_empty;
    assign count    = r_count;
    assign tx_valid = r_tx_valid;
    assign tx_data  = r_tx_data;
    assign idle     = r_empty && (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Scoreboard bench for uart_tx_fifo with a queue-based model
//               and a simple UART busy responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int DEPTH   = 256;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset, clear, wr_en, tx_busy;
    logic [7:0]  wr_data;
    logic        full, empty, tx_valid, idle, overflow;
    logic [8:0]  count;
    logic [7:0]  tx_data;
    logic [15:0] drop_cnt;

    uart_tx_fifo #(.DATA_WIDTH(8), .ADDR_BITS(8), .BUSY_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_busy(tx_busy), .idle(idle), .overflow(overflow),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte queue plus transmit phase
    logic [7:0]  mq[$];
    logic [7:0]  q_exp[$];
    int          m_phase = 0;     // 0 idle, 1 awaiting busy rise, 2 awaiting busy fall
    int          m_cyc = 0;
    int          m_launch_cyc = 0;
    int          m_sz0;
    logic [7:0]  m_last = 8'h00;
    logic        m_ovf = 1'b0;
    logic [15:0] m_drop = 16'h0;

    initial begin
        forever begin
            @(posedge clk);
            m_cyc++;
            if (reset) begin
                mq.delete();
                q_exp.delete();
                m_phase = 0;
                m_last  = 8'h00;
                m_ovf   = 1'b0;
                m_drop  = 16'h0;
            end else begin
                m_sz0 = mq.size();
                if (m_phase == 0 && m_sz0 > 0 && !tx_busy) begin
                    m_last = mq.pop_front();
                    q_exp.push_back(m_last);
                    m_phase = 1;
                    m_launch_cyc = m_cyc;
                end else if (m_phase == 1) begin
                    if (tx_busy) m_phase = 2;
                    else if (m_cyc - m_launch_cyc == TIMEOUT) m_phase = 0;
                end else if (m_phase == 2) begin
                    if (!tx_busy) m_phase = 0;
                end
`ifdef UART_TX_FIFO_STATS_EN
                if (wr_en && m_sz0 == DEPTH) begin
                    m_ovf = 1'b1;
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'h1;
                end
`endif
                if (clear) mq.delete();
                else if (wr_en && m_sz0 < DEPTH) mq.push_back(wr_data);
            end
        end
    end

    // UART responder: 0 normal, 1 hold busy, 2 never responds
    int mode = 0;
    int busy_len = 3;
    int busy_left = 0;

    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            case (mode)
                1: tx_busy = 1'b1;
                2: tx_busy = 1'b0;
                default: begin
                    if (busy_left > 0) begin
                        busy_left--;
                        if (busy_left == 0) tx_busy = 1'b0;
                    end else if (tx_valid) begin
                        tx_busy   = 1'b1;
                        busy_left = busy_len;
                    end else begin
                        tx_busy = 1'b0;
                    end
                end
            endcase
        end
    end

    // Monitor / scoreboard
    bit mon_on = 1'b0;
    logic [7:0] e_byte;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (q_exp.size() > 0) begin
                    e_byte = q_exp.pop_front();
                    chk("launch_valid", {31'b0, tx_valid}, 32'd1);
                    chk("launch_data", {24'b0, tx_data}, {24'b0, e_byte});
                end else begin
                    chk("no_launch", {31'b0, tx_valid}, 32'd0);
                    chk("tx_data_hold", {24'b0, tx_data}, {24'b0, m_last});
                end
                chk("count", {23'b0, count}, mq.size());
                chk("empty", {31'b0, empty}, {31'b0, mq.size() == 0});
                chk("full", {31'b0, full}, {31'b0, mq.size() == DEPTH});
                chk("idle", {31'b0, idle}, {31'b0, (mq.size() == 0) && (m_phase == 0)});
                chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
                chk("drop_cnt", {16'b0, drop_cnt}, {16'b0, m_drop});
            end
        end
    end

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_model_idle(input int max_cyc, input string name);
        bit done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge clk);
            if (mq.size() == 0 && m_phase == 0 && q_exp.size() == 0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: drain timeout actual=busy required=idle", name);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_count"}, {23'b0, count}, 32'd0);
        chk({tag, "_empty"}, {31'b0, empty}, 32'd1);
        chk({tag, "_full"}, {31'b0, full}, 32'd0);
        chk({tag, "_tx_valid"}, {31'b0, tx_valid}, 32'd0);
        chk({tag, "_tx_data"}, {24'b0, tx_data}, 32'd0);
        chk({tag, "_idle"}, {31'b0, idle}, 32'd1);
        chk({tag, "_overflow"}, {31'b0, overflow}, 32'd0);
        chk({tag, "_drop"}, {16'b0, drop_cnt}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset  = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);

        // Single byte latency
        busy_len = 4;
        push(8'h41);
        chk("lat_n_valid", {31'b0, tx_valid}, 32'd0);
        chk("lat_n_count", {23'b0, count}, 32'd1);
        @(negedge clk);
        chk("lat_n1_valid", {31'b0, tx_valid}, 32'd1);
        chk("lat_n1_data", {24'b0, tx_data}, 32'h41);
        chk("lat_n1_count", {23'b0, count}, 32'd0);
        wait_model_idle(100, "t1_drain");

        // Back-to-back bytes with a slow core
        busy_len = 10;
        for (int i = 1; i <= 5; i++) push(8'(i));
        wait_model_idle(200, "t2_drain");
        chk("t2_idle", {31'b0, idle}, 32'd1);

        // Fill while core holds busy, then overflow
        mode = 1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) push(8'(i));
        chk("t3_full", {31'b0, full}, 32'd1);
        chk("t3_count", {23'b0, count}, 32'd256);
        push(8'hEE);
        chk("t3_count_after_drop", {23'b0, count}, 32'd256);
`ifdef UART_TX_FIFO_STATS_EN
        chk("t3_overflow", {31'b0, overflow}, 32'd1);
        chk("t3_drop_cnt", {16'b0, drop_cnt}, 32'd1);
`endif
        busy_len = 2;
        mode = 0;
        wait_model_idle(DEPTH * 10, "t3_drain");
        chk("t3_last_byte", {24'b0, tx_data}, 32'hFF);

        // Core never acknowledges: timeout then next byte
        mode = 2;
        push(8'hA5);
        push(8'h5A);
        wait_model_idle(4 * TIMEOUT, "t4_drain");
        chk("t4_last_byte", {24'b0, tx_data}, 32'h5A);
        mode = 0;
        @(negedge clk);

        // Clear mid-transfer together with a write
        busy_len = 10;
        push(8'h11); push(8'h22); push(8'h33);
        repeat (3) @(negedge clk);
        clear = 1'b1; wr_en = 1'b1; wr_data = 8'h44;
        @(negedge clk);
        clear = 1'b0; wr_en = 1'b0;
        chk("t5_count", {23'b0, count}, 32'd0);
        chk("t5_empty", {31'b0, empty}, 32'd1);
        repeat (40) @(negedge clk);
        chk("t5_tx_data", {24'b0, tx_data}, 32'h11);

        // Reset while waiting for busy to fall with four bytes queued
        busy_len = 20;
        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
        chk("t6_pre_count", {23'b0, count}, 32'd4);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("t6");
        reset = 1'b0;
        repeat (25) @(negedge clk);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            wr_en   = ($urandom_range(0, 2) != 0);
            wr_data = 8'($urandom);
            clear   = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 49) == 0) busy_len = $urandom_range(1, 8);
            if ($urandom_range(0, 199) == 0) mode = $urandom_range(0, 2);
            if (mode != 0 && $urandom_range(0, 29) == 0) mode = 0;
            reset   = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        wr_en = 1'b0; clear = 1'b0; reset = 1'b0; mode = 0;
        wait_model_idle(DEPTH * 12 + 200, "rand_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
